// File: rtl/uart_rx_fifo.sv
// Receive FIFO behind the UART receiver: edge-captured bytes, first-word-fall-through read side.
// Optional idle-timeout flag is compiled in when UART_RX_FIFO_TIMEOUT_EN is defined.
module uart_rx_fifo #(
  parameter int DEPTH          = 16,
  parameter int ADDR_W         = $clog2(DEPTH),
  parameter int TIMEOUT_CYCLES = 3480
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic [7:0]        rd_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              empty,
  output logic              overflow,
  input  logic              overflow_clr,
  output logic              timeout_irq,
  input  logic              timeout_clr
);

  logic [7:0]      mem_q [DEPTH];
  logic [ADDR_W:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0] count_q, count_d;
  logic            rx_valid_q;
  logic            overflow_q, overflow_d;
  logic            push_req, push, pop, drop;

  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign full     = (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]) &&
                    (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]);
  assign rd_valid = ~empty;
  assign rd_data  = empty ? 8'h00 : mem_q[rd_ptr_q[ADDR_W-1:0]];
  assign count    = count_q;
  assign overflow = overflow_q;

  // A full FIFO can still take a byte when the head leaves in the same cycle.
  assign push_req = rx_valid & ~rx_valid_q;
  assign pop      = rd_valid & rd_ready;
  assign push     = push_req & (~full | pop);
  assign drop     = push_req & full & ~pop;

  always_comb begin
    wr_ptr_d   = wr_ptr_q + (ADDR_W+1)'(push);
    rd_ptr_d   = rd_ptr_q + (ADDR_W+1)'(pop);
    count_d    = count_q;
    overflow_d = overflow_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    if (drop)              overflow_d = 1'b1;
    else if (overflow_clr) overflow_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[ADDR_W-1:0]] <= rx_data;
  end

  // Edge detector starts at 1 so a level already high out of reset is not taken as a new byte.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      rx_valid_q <= 1'b1;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      rx_valid_q <= rx_valid;
    end
  end

`ifdef UART_RX_FIFO_TIMEOUT_EN
  localparam logic [15:0] IdleMax = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] idle_q, idle_d;
  logic        timeout_q, timeout_d;
  logic        timeout_set;

  always_comb begin
    idle_d = idle_q;
    if (push || pop || empty) idle_d = '0;
    else if (idle_q != IdleMax) idle_d = idle_q + 16'd1;
    timeout_set = ~empty && (idle_d == IdleMax) && (idle_q != IdleMax);
    timeout_d   = timeout_q;
    if (timeout_set)               timeout_d = 1'b1;
    else if (timeout_clr || empty) timeout_d = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idle_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      idle_q    <= idle_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout_irq = timeout_q;
`else
  logic unused_timeout;
  assign unused_timeout = timeout_clr | (TIMEOUT_CYCLES == 0);
  assign timeout_irq    = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: a cycle model queues accepted bytes, a negedge monitor checks every cycle.
module tb_uart_rx_fifo;
  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       rd_ready;
  logic [4:0] count;
  logic       full, empty, overflow, overflow_clr, timeout_irq, timeout_clr;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] exp_q[$];
  int         cnt_m = 0;
  logic       prev_m = 1'b1;
  logic       ovf_m = 1'b0;
  logic [7:0] last_pop = 8'h00;
  int         pops_seen = 0;

  always #5 clk = ~clk;

  uart_rx_fifo dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .count(count), .full(full), .empty(empty), .overflow(overflow),
    .overflow_clr(overflow_clr), .timeout_irq(timeout_irq), .timeout_clr(timeout_clr)
  );

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Cycle model: decides which bytes the FIFO must accept, from the inputs present at each edge.
  always @(posedge clk) begin
    bit pr, pp, ps;
    if (reset) begin
      cnt_m  = 0;
      prev_m = 1'b1;
      ovf_m  = 1'b0;
      exp_q.delete();
    end else begin
      pr = rx_valid && !prev_m;
      pp = (cnt_m > 0) && rd_ready;
      ps = pr && ((cnt_m < DEPTH) || pp);
      if (ps) exp_q.push_back(rx_data);
      if (pr && !ps) ovf_m = 1'b1;
      else if (overflow_clr) ovf_m = 1'b0;
      cnt_m  = cnt_m + int'(ps) - int'(pp);
      prev_m = rx_valid;
    end
  end

  // Monitor: status every cycle, head data whenever presented, pop from the scoreboard on handshake.
  always @(negedge clk) begin
    if (!reset) begin
      check("count", int'(count), cnt_m);
      check("full", int'(full), int'(cnt_m == DEPTH));
      check("empty", int'(empty), int'(cnt_m == 0));
      check("overflow", int'(overflow), int'(ovf_m));
      check("timeout_irq", int'(timeout_irq), 0);
      if (rd_valid) begin
        if (exp_q.size() == 0) check("rd_valid_with_empty_scoreboard", 1, 0);
        else check("rd_data", int'(rd_data), int'(exp_q[0]));
        if (rd_ready && exp_q.size() > 0) begin
          last_pop = exp_q.pop_front();
          pops_seen++;
          $display("pop data=%02h count=%0d", rd_data, count);
        end
      end else begin
        check("rd_data_idle", int'(rd_data), 0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
    tick();
  endtask

  task automatic drain(input int limit);
    rd_ready = 1'b1;
    for (int i = 0; i < limit && !empty; i++) tick();
    rd_ready = 1'b0;
    check("drain_empty", int'(empty), 1);
  endtask

  initial begin
    reset = 1'b0; rx_data = 8'h00; rx_valid = 1'b1; rd_ready = 1'b0;
    overflow_clr = 1'b0; timeout_clr = 1'b0;
    #2 reset = 1'b1;
    tick(); tick();
    check("rst_count", int'(count), 0);
    check("rst_empty", int'(empty), 1);
    check("rst_full", int'(full), 0);
    check("rst_rd_valid", int'(rd_valid), 0);
    check("rst_rd_data", int'(rd_data), 0);
    check("rst_overflow", int'(overflow), 0);
    check("rst_timeout", int'(timeout_irq), 0);
    reset = 1'b0;

    // rx_valid high across reset release must not push
    repeat (5) tick();
    check("held_valid_no_push", int'(count), 0);
    rx_valid = 1'b0;
    tick();

    // One long pulse captures exactly one byte, visible the cycle after the edge
    rx_data  = 8'hA5;
    rx_valid = 1'b1;
    tick();
    check("first_latency_valid", int'(rd_valid), 1);
    check("first_latency_data", int'(rd_data), 8'hA5);
    repeat (49) tick();
    check("long_pulse_count", int'(count), 1);
    rx_valid = 1'b0;
    tick();
    drain(4);
    check("a5_popped", int'(last_pop), 8'hA5);

    // Fill, overflow, clear, drain in order
    for (int i = 0; i < 16; i++) send_byte(8'(i));
    check("fill_full", int'(full), 1);
    check("fill_count", int'(count), 16);
    check("fill_no_ovf", int'(overflow), 0);
    send_byte(8'hFF);
    check("ovf_set", int'(overflow), 1);
    check("ovf_count", int'(count), 16);
    overflow_clr = 1'b1; tick(); overflow_clr = 1'b0;
    check("ovf_clr", int'(overflow), 0);
    drain(20);
    check("fill_last_pop", int'(last_pop), 8'h0F);

    // Full FIFO: push with simultaneous pop is accepted
    for (int i = 0; i < 16; i++) send_byte(8'h10 + 8'(i));
    rx_data = 8'hEE; rx_valid = 1'b1; rd_ready = 1'b1;
    tick();
    rx_valid = 1'b0; rd_ready = 1'b0;
    tick();
    check("full_pushpop_count", int'(count), 16);
    check("full_pushpop_ovf", int'(overflow), 0);
    drain(20);
    check("full_pushpop_last", int'(last_pop), 8'hEE);

    // Drop with overflow_clr in the same cycle: set wins
    for (int i = 0; i < 16; i++) send_byte(8'h30 + 8'(i));
    rx_data = 8'h77; rx_valid = 1'b1; overflow_clr = 1'b1;
    tick();
    rx_valid = 1'b0; overflow_clr = 1'b0;
    check("ovf_set_wins", int'(overflow), 1);
    tick();
    overflow_clr = 1'b1; tick(); overflow_clr = 1'b0;
    drain(20);
    check("setwins_last", int'(last_pop), 8'h3F);

    // Wrap: 40 bytes with rd_ready toggling every cycle
    for (int i = 0; i < 40; i++) begin
      rx_data  = 8'h40 + 8'(i);
      rx_valid = 1'b1;
      tick();
      rd_ready = ~rd_ready;
      rx_valid = 1'b0;
      tick();
      rd_ready = ~rd_ready;
    end
    drain(45);
    check("wrap_last", int'(last_pop), 8'h67);
    check("wrap_scoreboard_empty", exp_q.size(), 0);
    check("total_pops", pops_seen, 1 + 16 + 17 + 16 + 40);

    tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
